// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter: grants ownership, deserializes the owner's
// slave-select frame, drives routing outputs and reclaims the bus on drop or timeout.
module bus_arbiter #(
  parameter int SLAVE_LEN = 2,
  parameter int SEL_WAIT  = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_m1,
  input  logic                 req_m2,
  input  logic                 sel_m1,
  input  logic                 sel_m2,
  output logic                 grant_m1,
  output logic                 grant_m2,
  output logic                 busy_m1,
  output logic                 busy_m2,
  output logic                 owner,
  output logic [SLAVE_LEN-1:0] slave_id,
  output logic                 slave_en,
  output logic                 timeout_err
);

  localparam int WW = $clog2(SEL_WAIT + 1);
  localparam int HW = $clog2(TIMEOUT + 1);
  localparam int BW = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(SEL_WAIT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(TIMEOUT);
  localparam logic [BW-1:0] BIT_LAST = BW'(SLAVE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ADDR,
    S_ACTIVE,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SLAVE_LEN-1:0] sid_q, sid_d;
  logic                 to_q, to_d;

  logic                 g1_q, g1_d, g2_q, g2_d;
  logic                 b1_q, b1_d, b2_q, b2_d;
  logic                 own_o_q, own_o_d;
  logic [SLAVE_LEN-1:0] sid_o_q, sid_o_d;
  logic                 en_q, en_d;
  logic                 terr_q, terr_d;

  logic own_req;
  logic own_sel;
  logic pick;

  assign own_req = owner_q ? req_m2 : req_m1;
  assign own_sel = owner_q ? sel_m2 : sel_m1;
  // Both requesting: the master that did not own last wins; otherwise the lone requester.
  assign pick    = req_m2 & (~req_m1 | ~last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wait_q  <= '0;
      hold_q  <= '0;
      bit_q   <= '0;
      sid_q   <= '0;
      to_q    <= 1'b0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      b1_q    <= 1'b0;
      b2_q    <= 1'b0;
      own_o_q <= 1'b0;
      sid_o_q <= '0;
      en_q    <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      sid_q   <= sid_d;
      to_q    <= to_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      own_o_q <= own_o_d;
      sid_o_q <= sid_o_d;
      en_q    <= en_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    bit_d   = bit_q;
    sid_d   = sid_q;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_m1 || req_m2) begin
          owner_d = pick;
          last_d  = pick;
          wait_d  = '0;
          sid_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          state_d = S_RELEASE;
        end else if (own_sel) begin
          bit_d   = '0;
          state_d = S_ADDR;
        end else begin
          wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
          if (wait_d == WAIT_MAX) begin
            to_d    = 1'b1;
            state_d = S_RELEASE;
          end
        end
      end
      S_ADDR: begin
        if (!own_req) begin
          state_d = S_RELEASE;
        end else begin
          sid_d[bit_q] = own_sel;
          if (bit_q == BIT_LAST) begin
            hold_d  = '0;
            state_d = S_ACTIVE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        // A request drop on the limit cycle wins and is a normal release.
        if (!own_req) begin
          state_d = S_RELEASE;
        end else begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
          if (hold_d == HOLD_MAX) begin
            to_d    = 1'b1;
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        sid_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they trail it by a cycle.
  always_comb begin
    g1_d    = 1'b0;
    g2_d    = 1'b0;
    b1_d    = 1'b0;
    b2_d    = 1'b0;
    en_d    = 1'b0;
    sid_o_d = '0;
    own_o_d = owner_q;
    terr_d  = (state_q == S_RELEASE) && to_q;
    case (state_q)
      S_GRANT, S_ADDR: begin
        g1_d = ~owner_q;
        g2_d = owner_q;
        b1_d = 1'b1;
        b2_d = 1'b1;
      end
      S_ACTIVE: begin
        g1_d    = ~owner_q;
        g2_d    = owner_q;
        b1_d    = owner_q;
        b2_d    = ~owner_q;
        en_d    = 1'b1;
        sid_o_d = sid_q;
      end
      default: ;
    endcase
  end

  assign grant_m1    = g1_q;
  assign grant_m2    = g2_q;
  assign busy_m1     = b1_q;
  assign busy_m2     = b2_q;
  assign owner       = own_o_q;
  assign slave_id    = sid_o_q;
  assign slave_en    = en_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: routing frames are queued when sent and
// popped when slave_en appears; each scenario task checks its own results.
module tb_bus_arbiter;
  localparam int SL = 2;
  localparam int SW = 6;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset, req_m1, req_m2, sel_m1, sel_m2;
  logic          grant_m1, grant_m2, busy_m1, busy_m2, owner, slave_en, timeout_err;
  logic [SL-1:0] slave_id;

  int checks   = 0;
  int failures = 0;
  logic [SL:0] exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(.SLAVE_LEN(SL), .SEL_WAIT(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_m1(req_m1), .req_m2(req_m2), .sel_m1(sel_m1), .sel_m2(sel_m2),
    .grant_m1(grant_m1), .grant_m2(grant_m2), .busy_m1(busy_m1), .busy_m2(busy_m2),
    .owner(owner), .slave_id(slave_id), .slave_en(slave_en), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_m1 = 1'b0; req_m2 = 1'b0; sel_m1 = 1'b0; sel_m2 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_sel(input logic m, input logic v);
    if (m) sel_m2 = v;
    else sel_m1 = v;
  endtask

  task automatic send_addr(input logic m, input logic [SL-1:0] id);
    drive_sel(m, 1'b1);
    tick();
    for (int k = 0; k < SL; k++) begin
      drive_sel(m, id[k]);
      tick();
    end
    drive_sel(m, 1'b0);
    exp_q.push_back({m, id});
  endtask

  task automatic collect(output logic got_en, output logic [SL:0] got, output logic [SL:0] exp);
    int n = 0;
    while (slave_en !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    got_en = slave_en;
    got    = {owner, slave_id};
    exp    = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
  endtask

  task automatic wait_any_grant(output int n);
    n = 0;
    while (!(grant_m1 === 1'b1 || grant_m2 === 1'b1) && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant_m1, grant_m2, busy_m1, busy_m2, owner, slave_en, timeout_err, slave_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got g=%b%b b=%b%b own=%b en=%b to=%b id=%b required all 0",
               grant_m1, grant_m2, busy_m1, busy_m2, owner, slave_en, timeout_err, slave_id);
    end
  endtask

  task automatic test_single();
    logic en;
    logic [SL:0] got, exp;
    do_reset();
    req_m1 = 1'b1;
    tick();
    checks++;
    if (grant_m1 !== 1'b0) begin
      failures++; $display("FAIL single_latency: grant_m1=%b required 0 one edge after request", grant_m1);
    end
    tick();
    checks++;
    if ({grant_m1, grant_m2, busy_m1, busy_m2, owner} !== 5'b10110) begin
      failures++;
      $display("FAIL single_grant: g=%b%b b=%b%b own=%b required g=10 b=11 own=0",
               grant_m1, grant_m2, busy_m1, busy_m2, owner);
    end
    send_addr(1'b0, 2'b10);
    collect(en, got, exp);
    checks++;
    if ({en, got} !== {1'b1, exp}) begin
      failures++; $display("FAIL single_route: en=%b {owner,id}=%b required en=1 %b", en, got, exp);
    end
    checks++;
    if ({busy_m1, busy_m2} !== 2'b01) begin
      failures++; $display("FAIL single_busy: busy=%b%b required 01", busy_m1, busy_m2);
    end
    req_m1 = 1'b0;
    tick();
    checks++;
    if (grant_m1 !== 1'b1) begin
      failures++; $display("FAIL single_hold_edge: grant_m1=%b required 1 at sampling edge", grant_m1);
    end
    tick();
    checks++;
    if ({grant_m1, grant_m2, busy_m1, busy_m2, slave_en, timeout_err, slave_id} !== '0) begin
      failures++;
      $display("FAIL single_release: g=%b%b b=%b%b en=%b to=%b id=%b required all 0",
               grant_m1, grant_m2, busy_m1, busy_m2, slave_en, timeout_err, slave_id);
    end
    checks++;
    if (owner !== 1'b0) begin
      failures++; $display("FAIL single_owner_kept: owner=%b required 0", owner);
    end
  endtask

  task automatic test_contention();
    logic en;
    logic [SL:0] got, exp;
    int n, low;
    do_reset();
    req_m1 = 1'b1; req_m2 = 1'b1;
    wait_any_grant(n);
    checks++;
    if ({grant_m1, grant_m2} !== 2'b10) begin
      failures++; $display("FAIL first_contention: g=%b%b required 10", grant_m1, grant_m2);
    end
    send_addr(1'b0, 2'b01);
    collect(en, got, exp);
    checks++;
    if ({en, got} !== {1'b1, exp}) begin
      failures++; $display("FAIL m1_route: en=%b {owner,id}=%b required en=1 %b", en, got, exp);
    end
    req_m1 = 1'b0;
    n = 0; low = 0;
    while (grant_m2 !== 1'b1 && n < 12) begin
      tick();
      n++;
      if (grant_m1 === 1'b0 && grant_m2 === 1'b0) low++;
    end
    checks++;
    if (n != 4 || low != 2) begin
      failures++; $display("FAIL handover_gap: edges=%0d low=%0d required edges=4 low=2", n, low);
    end
    send_addr(1'b1, 2'b11);
    collect(en, got, exp);
    checks++;
    if ({en, got} !== {1'b1, exp}) begin
      failures++; $display("FAIL m2_route: en=%b {owner,id}=%b required en=1 %b", en, got, exp);
    end
    req_m2 = 1'b0; req_m1 = 1'b1;
    tick();
    tick();
    req_m2 = 1'b1;
    wait_any_grant(n);
    checks++;
    if ({grant_m1, grant_m2} !== 2'b10) begin
      failures++; $display("FAIL round_robin: g=%b%b required 10", grant_m1, grant_m2);
    end
  endtask

  task automatic test_missing_start();
    int n;
    logic seen_en;
    do_reset();
    req_m2 = 1'b1;
    wait_any_grant(n);
    checks++;
    if ({grant_m1, grant_m2, owner} !== 3'b011) begin
      failures++; $display("FAIL sel_wait_grant: g=%b%b own=%b required 01 own=1", grant_m1, grant_m2, owner);
    end
    n = 0; seen_en = 1'b0;
    while (timeout_err !== 1'b1 && n < 30) begin
      tick();
      n++;
      if (slave_en === 1'b1) seen_en = 1'b1;
    end
    checks++;
    if (n != SW || grant_m2 !== 1'b0) begin
      failures++; $display("FAIL sel_wait_timeout: edges=%0d grant_m2=%b required edges=%0d grant_m2=0", n, grant_m2, SW);
    end
    req_m2 = 1'b0;
    tick();
    checks++;
    if (timeout_err !== 1'b0 || seen_en !== 1'b0) begin
      failures++; $display("FAIL sel_wait_pulse: timeout_err=%b slave_en_seen=%b required 0 0", timeout_err, seen_en);
    end
  endtask

  task automatic test_hold_timeout();
    logic en;
    logic [SL:0] got, exp;
    int n;
    do_reset();
    req_m1 = 1'b1;
    wait_any_grant(n);
    send_addr(1'b0, 2'b11);
    collect(en, got, exp);
    checks++;
    if ({en, got} !== {1'b1, exp}) begin
      failures++; $display("FAIL hold_route: en=%b {owner,id}=%b required en=1 %b", en, got, exp);
    end
    n = 0;
    while (timeout_err !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != TO || grant_m1 !== 1'b0 || slave_en !== 1'b0) begin
      failures++; $display("FAIL hold_timeout: edges=%0d g1=%b en=%b required edges=%0d g1=0 en=0", n, grant_m1, slave_en, TO);
    end
    wait_any_grant(n);
    checks++;
    if ({grant_m1, grant_m2} !== 2'b10) begin
      failures++; $display("FAIL hold_regrant_alone: g=%b%b required 10", grant_m1, grant_m2);
    end
    send_addr(1'b0, 2'b01);
    collect(en, got, exp);
    checks++;
    if ({en, got} !== {1'b1, exp}) begin
      failures++; $display("FAIL hold_route2: en=%b {owner,id}=%b required en=1 %b", en, got, exp);
    end
    req_m2 = 1'b1;
    n = 0;
    while (timeout_err !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    wait_any_grant(n);
    checks++;
    if ({grant_m1, grant_m2} !== 2'b01) begin
      failures++; $display("FAIL hold_yield_to_m2: g=%b%b required 01", grant_m1, grant_m2);
    end
  endtask

  task automatic test_reset_mid_addr();
    logic en;
    logic [SL:0] got, exp;
    int n;
    do_reset();
    req_m2 = 1'b1;
    wait_any_grant(n);
    sel_m2 = 1'b1;
    tick();
    sel_m2 = 1'b1;
    tick();
    sel_m2 = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({grant_m1, grant_m2, busy_m1, busy_m2, owner, slave_en, timeout_err, slave_id} !== '0) begin
      failures++;
      $display("FAIL reset_mid_addr: g=%b%b b=%b%b own=%b en=%b to=%b id=%b required all 0",
               grant_m1, grant_m2, busy_m1, busy_m2, owner, slave_en, timeout_err, slave_id);
    end
    wait_any_grant(n);
    checks++;
    if ({grant_m1, grant_m2} !== 2'b01) begin
      failures++; $display("FAIL reset_regrant: g=%b%b required 01", grant_m1, grant_m2);
    end
    send_addr(1'b1, 2'b10);
    collect(en, got, exp);
    checks++;
    if ({en, got} !== {1'b1, exp}) begin
      failures++; $display("FAIL reset_route: en=%b {owner,id}=%b required en=1 %b", en, got, exp);
    end
  endtask

  task automatic test_abort_grant();
    int n;
    logic bad;
    do_reset();
    req_m1 = 1'b1;
    wait_any_grant(n);
    req_m1 = 1'b0;
    tick();
    tick();
    checks++;
    if (grant_m1 !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL abort_release: g1=%b to=%b required 0 0", grant_m1, timeout_err);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (timeout_err !== 1'b0 || slave_en !== 1'b0 || grant_m1 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL abort_quiet: activity seen=%b required 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1; req_m1 = 1'b0; req_m2 = 1'b0; sel_m1 = 1'b0; sel_m2 = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_missing_start();
    test_hold_timeout();
    test_reset_mid_addr();
    test_abort_grant();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: left=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
